serial_pattern_tx: RTL

- Serial bit-stream transmitter that drives sequence detectors such as the 101 Mealy detector.
- Accepts a parallel word through a load/ready handshake and shifts it out MSB-first on a single-bit line, one bit per clock.
- Inserts a programmable idle gap between words.
- Keeps a reference count of overlapping "101" occurrences on the line, so a bench or self-test can compare it directly with the detector's output pulses.

---
 rtl/serial_pattern_tx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/serial_pattern_tx.sv
// Serial word transmitter: shifts a parallel word out MSB-first with a programmable
// idle gap, and keeps a saturating count of overlapping "101" patterns driven on x.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    input  logic             clr_cnt,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] exp_cnt
);

    localparam int               BW       = $clog2(WIDTH);
    localparam logic [BW-1:0]    LAST_BIT = BW'(WIDTH - 1);
    localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam bit               CHAIN    = (GAP == 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [3:0]       gap_q, gap_d;
    logic             x_q, x_d;
    logic             xv_q, xv_d;
    logic             done_q, done_d;
    logic             h1_q, h0_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             match;

    // With no gap, the last-bit cycle also accepts the next word so words chain back to back.
    always_comb begin
        ready  = (state_q == S_IDLE) ||
                 (CHAIN && (state_q == S_SHIFT) && (bit_q == LAST_BIT));
        accept = load && ready;
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        x_d     = 1'b0;
        xv_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
            end
            S_SHIFT: begin
                if (bit_q == LAST_BIT) begin
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = CHAIN ? S_IDLE : S_GAP;
                end else begin
                    x_d     = shreg_q[WIDTH-1];
                    xv_d    = 1'b1;
                    shreg_d = shreg_q << 1;
                    bit_d   = bit_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An accepted load overrides the per-state defaults; done from the case is kept.
        if (accept) begin
            x_d     = data_in[WIDTH-1];
            xv_d    = 1'b1;
            shreg_d = data_in << 1;
            bit_d   = '0;
            state_d = S_SHIFT;
        end
    end

    // Pattern tracking sees every value registered onto x, so it lines up with a Mealy detector.
    always_comb begin
        match = x_d && h1_q && !h0_q;
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
            done_q  <= 1'b0;
            h1_q    <= 1'b0;
            h0_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            done_q  <= done_d;
            h1_q    <= h0_q;
            h0_q    <= x_d;
            cnt_q   <= cnt_d;
        end
    end

    assign x       = x_q;
    assign x_valid = xv_q;
    assign done    = done_q;
    assign busy    = (state_q != S_IDLE);
    assign exp_cnt = cnt_q;

endmodule
